// File: rtl/key_lut_pkg.sv
// Shared types and constants for the runtime-programmable key lookup table.
package key_lut_pkg;

   // A miss returns all-zero, or returns the default_out value captured at accept.
   localparam bit DEFAULT_MODE_ZERO  = 1'b0;
   localparam bit DEFAULT_MODE_VALUE = 1'b1;

   // Entry index width; an index needs at least one bit even for a 2-entry table.
   function automatic int idx_width(input int nr_key);
      return (nr_key > 2) ? $clog2(nr_key) : 1;
   endfunction

   // Packed width of one {vld, key, data} entry.
   function automatic int entry_width(input int key_len, input int data_len);
      return 1 + key_len + data_len;
   endfunction

endpackage

// File: rtl/key_lut_table_if.sv
// Write, clear and lookup signals of key_lut_table; the table is the slave.
// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// valid must not depend on ready, and data is held while valid && !ready.
interface key_lut_table_if #(
   parameter int KEY_LEN  = 4,
   parameter int DATA_LEN = 8,
   parameter int IDX_W    = 3
);
   logic                wr_en;
   logic [IDX_W-1:0]    wr_idx;
   logic [KEY_LEN-1:0]  wr_key;
   logic [DATA_LEN-1:0] wr_data;
   logic                clr;
   logic                in_valid;
   logic                in_ready;
   logic [KEY_LEN-1:0]  in_key;
   logic [DATA_LEN-1:0] default_out;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_LEN-1:0] out_data;
   logic                out_hit;

   modport master (
      output wr_en, wr_idx, wr_key, wr_data, clr,
      output in_valid, in_key, default_out, out_ready,
      input  in_ready, out_valid, out_data, out_hit
   );

   modport slave (
      input  wr_en, wr_idx, wr_key, wr_data, clr,
      input  in_valid, in_key, default_out, out_ready,
      output in_ready, out_valid, out_data, out_hit
   );
endinterface

// File: rtl/key_lut_table_pri_match.sv
// Combinational key comparator with lowest-index-wins priority encoding.
module key_pri_match #(
   parameter int NR_KEY  = 8,
   parameter int KEY_LEN = 4,
   parameter int IDX_W   = 3
) (
   input  logic [NR_KEY-1:0]              i_vld,
   input  logic [NR_KEY-1:0][KEY_LEN-1:0] i_keys,
   input  logic [KEY_LEN-1:0]             i_key,
   output logic                           o_hit,
   output logic [IDX_W-1:0]               o_idx
);

   // Scanning from the top down lets the lowest matching index overwrite the rest.
   always_comb begin
      o_hit = 1'b0;
      o_idx = '0;
      for (int i = NR_KEY - 1; i >= 0; i--) begin
         if (i_vld[i] && (i_keys[i] == i_key)) begin
            o_hit = 1'b1;
            o_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/key_lut_table.sv
// Programmable key->data table with a one-deep registered, stall-tolerant lookup output.
module key_lut_table
   import key_lut_pkg::*;
#(
   parameter int NR_KEY     = 8,
   parameter int KEY_LEN    = 4,
   parameter int DATA_LEN   = 8,
   parameter bit DEFAULT_EN = 1'b1
) (
   input logic            clk,
   input logic            rst,
   key_lut_table_if.slave bus
);

   localparam int IDX_W = idx_width(NR_KEY);

   typedef struct packed {
      logic                vld;
      logic [KEY_LEN-1:0]  key;
      logic [DATA_LEN-1:0] data;
   } entry_t;

   entry_t [NR_KEY-1:0]              r_tab;
   logic                             r_out_valid;
   logic [DATA_LEN-1:0]              r_out_data;
   logic                             r_out_hit;

   logic [NR_KEY-1:0]                w_vld;
   logic [NR_KEY-1:0][KEY_LEN-1:0]   w_keys;
   logic                             w_hit;
   logic [IDX_W-1:0]                 w_idx;
   logic                             w_accept;
   logic [DATA_LEN-1:0]              w_miss_data;
   logic [DATA_LEN-1:0]              w_lookup_data;

   always_comb begin
      for (int i = 0; i < NR_KEY; i++) begin
         w_vld[i]  = r_tab[i].vld;
         w_keys[i] = r_tab[i].key;
      end
   end

   key_pri_match #(
      .NR_KEY  (NR_KEY),
      .KEY_LEN (KEY_LEN),
      .IDX_W   (IDX_W)
   ) u_match (
      .i_vld  (w_vld),
      .i_keys (w_keys),
      .i_key  (bus.in_key),
      .o_hit  (w_hit),
      .o_idx  (w_idx)
   );

   // The output slot frees up in the same cycle the consumer takes the held result.
   assign bus.in_ready = !r_out_valid || bus.out_ready;
   assign w_accept     = bus.in_valid && bus.in_ready;

   assign w_miss_data   = (DEFAULT_EN == DEFAULT_MODE_VALUE) ? bus.default_out : '0;
   assign w_lookup_data = w_hit ? r_tab[w_idx].data : w_miss_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tab       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_hit   <= 1'b0;
      end else begin
         // A write wins over clr for its own entry, so clr+write leaves only that entry valid.
         for (int i = 0; i < NR_KEY; i++) begin
            if (bus.wr_en && (bus.wr_idx == IDX_W'(i))) begin
               r_tab[i].vld  <= 1'b1;
               r_tab[i].key  <= bus.wr_key;
               r_tab[i].data <= bus.wr_data;
            end else if (bus.clr) begin
               r_tab[i].vld <= 1'b0;
            end
         end

         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_lookup_data;
            r_out_hit   <= w_hit;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_hit   = r_out_hit;

endmodule

// File: tb/tb_key_lut_table.sv
// Bench for key_lut_table: one DEFAULT_EN=1 and one DEFAULT_EN=0 instance driven in lockstep.
module tb_key_lut_table;

   localparam int NR = 6;
   localparam int KL = 4;
   localparam int DL = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [KL-1:0] wr_key;
   logic [DL-1:0] wr_data;
   logic          clr;
   logic          in_valid;
   logic [KL-1:0] in_key;
   logic [DL-1:0] default_out;
   logic          out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: table contents plus the expected registered output for each build.
   logic          m_vld [NR];
   logic [KL-1:0] m_key [NR];
   logic [DL-1:0] m_data[NR];
   logic          m_ov;
   logic          m_hit;
   logic [DL-1:0] m_od1;
   logic [DL-1:0] m_od0;

   logic [DL:0]   exp_q[$];

   key_lut_table_if #(.KEY_LEN(KL), .DATA_LEN(DL), .IDX_W(IW)) if1 ();
   key_lut_table_if #(.KEY_LEN(KL), .DATA_LEN(DL), .IDX_W(IW)) if0 ();

   assign if1.wr_en = wr_en;       assign if0.wr_en = wr_en;
   assign if1.wr_idx = wr_idx;     assign if0.wr_idx = wr_idx;
   assign if1.wr_key = wr_key;     assign if0.wr_key = wr_key;
   assign if1.wr_data = wr_data;   assign if0.wr_data = wr_data;
   assign if1.clr = clr;           assign if0.clr = clr;
   assign if1.in_valid = in_valid; assign if0.in_valid = in_valid;
   assign if1.in_key = in_key;     assign if0.in_key = in_key;
   assign if1.default_out = default_out; assign if0.default_out = default_out;
   assign if1.out_ready = out_ready;     assign if0.out_ready = out_ready;

   key_lut_table #(.NR_KEY(NR), .KEY_LEN(KL), .DATA_LEN(DL), .DEFAULT_EN(1'b1)) dut1 (
      .clk (clk), .rst (rst), .bus (if1)
   );
   key_lut_table #(.NR_KEY(NR), .KEY_LEN(KL), .DATA_LEN(DL), .DEFAULT_EN(1'b0)) dut0 (
      .clk (clk), .rst (rst), .bus (if0)
   );

   // Clock / reset
   always #5 clk = ~clk;

   function automatic void model_lookup(input logic [KL-1:0] k, output logic h, output logic [DL-1:0] d);
      h = 1'b0;
      d = '0;
      for (int i = 0; i < NR; i++) begin
         if (!h && m_vld[i] && m_key[i] == k) begin
            h = 1'b1;
            d = m_data[i];
         end
      end
   endfunction

   // Advance one clock; the model sees the same inputs the DUTs sample at the edge.
   task automatic tick();
      logic          acc;
      logic          h;
      logic [DL-1:0] d;
      acc = in_valid && (!m_ov || out_ready);
      model_lookup(in_key, h, d);
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < NR; i++) begin
            m_vld[i] = 1'b0; m_key[i] = '0; m_data[i] = '0;
         end
         m_ov = 1'b0; m_hit = 1'b0; m_od1 = '0; m_od0 = '0;
      end else begin
         if (acc) begin
            m_ov  = 1'b1;
            m_hit = h;
            m_od1 = h ? d : default_out;
            m_od0 = h ? d : '0;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
         if (clr) for (int i = 0; i < NR; i++) m_vld[i] = 1'b0;
         if (wr_en && int'(wr_idx) < NR) begin
            m_vld[wr_idx] = 1'b1; m_key[wr_idx] = wr_key; m_data[wr_idx] = wr_data;
         end
      end
      #1;
   endtask

   // Driver tasks
   task automatic drive_idle();
      wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0; clr = 1'b0;
      in_valid = 1'b0; in_key = '0; default_out = '0; out_ready = 1'b0;
   endtask

   task automatic drive_write(input int idx, input int key, input int data);
      wr_en = 1'b1; wr_idx = IW'(idx); wr_key = KL'(key); wr_data = DL'(data);
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      n_checks++; if (if1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", if1.out_valid); end
      n_checks++; if (if1.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", if1.out_data); end
      n_checks++; if (if1.out_hit !== 1'b0) begin n_fail++; $display("FAIL reset_out_hit: got %b expected 0", if1.out_hit); end
      n_checks++; if (if1.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", if1.in_ready); end
   endtask

   task automatic test_default_miss();
      out_ready = 1'b1; in_valid = 1'b1; in_key = 4'h3; default_out = 8'hAA;
      tick();
      n_checks++; if (if1.out_valid !== 1'b1) begin n_fail++; $display("FAIL miss_out_valid: got %b expected 1", if1.out_valid); end
      n_checks++; if (if1.out_hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit: got %b expected 0", if1.out_hit); end
      n_checks++; if (if1.out_data !== 8'hAA) begin n_fail++; $display("FAIL miss_default_data: got %h expected aa", if1.out_data); end
      default_out = 8'hFF;
      tick();
      in_valid = 1'b0;
      n_checks++; if (if0.out_data !== 8'h00) begin n_fail++; $display("FAIL miss_zero_mode: got %h expected 00", if0.out_data); end
      n_checks++; if (if1.out_data !== 8'hFF) begin n_fail++; $display("FAIL miss_default_ff: got %h expected ff", if1.out_data); end
   endtask

   task automatic test_write_visibility();
      drive_write(2, 3, 8'h55);
      in_valid = 1'b1; in_key = 4'h3; default_out = 8'hAA;
      tick();
      wr_en = 1'b0;
      n_checks++; if (if1.out_hit !== 1'b0) begin n_fail++; $display("FAIL same_cycle_write_hit: got %b expected 0", if1.out_hit); end
      n_checks++; if (if1.out_data !== m_od1) begin n_fail++; $display("FAIL same_cycle_write_data: got %h expected %h", if1.out_data, m_od1); end
      tick();
      in_valid = 1'b0;
      n_checks++; if (if1.out_hit !== 1'b1) begin n_fail++; $display("FAIL next_cycle_hit: got %b expected 1", if1.out_hit); end
      n_checks++; if (if0.out_data !== 8'h55) begin n_fail++; $display("FAIL next_cycle_data: got %h expected 55", if0.out_data); end
   endtask

   task automatic test_priority_clr();
      drive_write(1, 7, 8'h11); tick();
      drive_write(5, 7, 8'h22); tick();
      wr_en = 1'b0;
      in_valid = 1'b1; in_key = 4'h7; tick(); in_valid = 1'b0;
      n_checks++; if (if1.out_data !== 8'h11 || if1.out_hit !== 1'b1) begin n_fail++; $display("FAIL priority_low_idx: got %h/%b expected 11/1", if1.out_data, if1.out_hit); end
      clr = 1'b1; drive_write(5, 7, 8'h22); tick();
      clr = 1'b0; wr_en = 1'b0;
      in_valid = 1'b1; in_key = 4'h7; tick(); in_valid = 1'b0;
      n_checks++; if (if1.out_data !== 8'h22 || if1.out_hit !== 1'b1) begin n_fail++; $display("FAIL clr_then_write: got %h/%b expected 22/1", if1.out_data, if1.out_hit); end
      drive_write(NR, 9, 8'h99); tick();
      drive_write(NR + 1, 9, 8'h98); tick();
      wr_en = 1'b0;
      in_valid = 1'b1; in_key = 4'h9; default_out = 8'hFF; tick(); in_valid = 1'b0;
      n_checks++; if (if1.out_hit !== 1'b0) begin n_fail++; $display("FAIL out_of_range_write_hit: got %b expected 0", if1.out_hit); end
      n_checks++; if (if0.out_data !== 8'h00) begin n_fail++; $display("FAIL out_of_range_zero_data: got %h expected 00", if0.out_data); end
      in_key = 4'h7; in_valid = 1'b1; tick(); in_valid = 1'b0;
      n_checks++; if (if1.out_data !== 8'h22) begin n_fail++; $display("FAIL out_of_range_table_kept: got %h expected 22", if1.out_data); end
   endtask

   task automatic test_stall();
      logic [DL-1:0] held;
      in_valid = 1'b0; out_ready = 1'b1; tick();
      out_ready = 1'b0; in_valid = 1'b1; in_key = 4'h7; tick();
      held = m_od1;
      n_checks++; if (if1.out_data !== 8'h22) begin n_fail++; $display("FAIL stall_first_result: got %h expected 22", if1.out_data); end
      for (int c = 0; c < 3; c++) begin
         drive_write(5, 7, $urandom_range(0, 255));
         in_key = KL'($urandom_range(0, 15));
         tick();
         wr_en = 1'b0;
         n_checks++; if (if1.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c%0d: got %b expected 0", c, if1.in_ready); end
         n_checks++; if (if1.out_valid !== 1'b1 || if1.out_data !== held || if1.out_hit !== 1'b1) begin
            n_fail++; $display("FAIL stall_hold c%0d: got %b/%h/%b expected 1/%h/1", c, if1.out_valid, if1.out_data, if1.out_hit, held);
         end
      end
      in_valid = 1'b0;
   endtask

   // Scoreboard over a long run: 16 cycles of full throughput, then random stalls, writes and clears.
   task automatic test_back_to_back();
      logic          h;
      logic [DL-1:0] d;
      logic [DL:0]   got;
      int            n_acc  = 0;
      int            n_out  = 0;
      int            n_thru = 0;
      exp_q.delete();
      exp_q.push_back({m_hit, m_od1});
      n_acc = 1;
      for (int c = 0; c < 60; c++) begin
         out_ready   = (c < 16) ? 1'b1 : 1'($urandom_range(0, 1));
         in_valid    = (c < 16) ? 1'b1 : 1'($urandom_range(0, 1));
         in_key      = KL'($urandom_range(0, 7));
         default_out = DL'($urandom);
         wr_en       = 1'($urandom_range(0, 1));
         wr_idx      = IW'($urandom_range(0, 7));
         wr_key      = KL'($urandom_range(0, 7));
         wr_data     = DL'($urandom);
         clr         = ($urandom_range(0, 9) == 0);
         #1;
         n_checks++; if (if1.in_ready !== (!m_ov || out_ready)) begin n_fail++; $display("FAIL b2b_in_ready c%0d: got %b expected %b", c, if1.in_ready, !m_ov || out_ready); end
         n_checks++; if (if1.out_valid !== m_ov) begin n_fail++; $display("FAIL b2b_out_valid c%0d: got %b expected %b", c, if1.out_valid, m_ov); end
         if (if1.out_valid && out_ready) begin
            got = {if1.out_hit, if1.out_data};
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra_result c%0d: got %h expected none", c, got); end
            else begin
               if (got !== exp_q[0]) begin n_fail++; $display("FAIL b2b_result c%0d: got %h expected %h", c, got, exp_q[0]); end
               void'(exp_q.pop_front());
            end
            n_out++;
            if (c < 16) n_thru++;
         end
         if (in_valid && (!m_ov || out_ready)) begin
            model_lookup(in_key, h, d);
            exp_q.push_back({h, h ? d : default_out});
            n_acc++;
         end
         tick();
      end
      drive_idle();
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (if1.out_valid) begin
            got = {if1.out_hit, if1.out_data};
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL drain_extra_result: got %h expected none", got); end
            else begin
               if (got !== exp_q[0]) begin n_fail++; $display("FAIL drain_result: got %h expected %h", got, exp_q[0]); end
               void'(exp_q.pop_front());
            end
            n_out++;
         end
         tick();
      end
      n_checks++; if (n_out !== n_acc || exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_count: got %0d results expected %0d", n_out, n_acc); end
      n_checks++; if (n_thru !== 16) begin n_fail++; $display("FAIL b2b_throughput: got %0d results in 16 cycles expected 16", n_thru); end
   endtask

   task automatic test_reset_mid();
      drive_idle();
      out_ready = 1'b1;
      drive_write(0, 10, 8'h5A); tick();
      wr_en = 1'b0;
      out_ready = 1'b0; in_valid = 1'b1; in_key = 4'hA; tick();
      n_checks++; if (if1.out_valid !== 1'b1 || if1.out_hit !== 1'b1 || if1.out_data !== 8'h5A) begin
         n_fail++; $display("FAIL pre_reset_hit: got %b/%b/%h expected 1/1/5a", if1.out_valid, if1.out_hit, if1.out_data);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++; if (if1.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out_valid: got %b expected 0", if1.out_valid); end
      out_ready = 1'b1; default_out = 8'h3C; tick(); in_valid = 1'b0;
      n_checks++; if (if1.out_hit !== 1'b0 || if1.out_data !== 8'h3C) begin n_fail++; $display("FAIL post_reset_miss: got %b/%h expected 0/3c", if1.out_hit, if1.out_data); end
      n_checks++; if (if0.out_data !== 8'h00) begin n_fail++; $display("FAIL post_reset_zero: got %h expected 00", if0.out_data); end
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin
         m_vld[i] = 1'b0; m_key[i] = '0; m_data[i] = '0;
      end
      m_ov = 1'b0; m_hit = 1'b0; m_od1 = '0; m_od0 = '0;
      rst = 1'b1;
      drive_idle();
      test_reset();
      test_default_miss();
      test_write_visibility();
      test_priority_clr();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
